// File: rtl/packet_tx_rmii.sv
// packet_tx_rmii: AXI-Stream payload in, RMII 2-bit Ethernet frame out.
// Define PACKET_TX_PAD_EN to zero-pad short payloads to MIN_PAYLOAD.
module packet_tx_rmii #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD    = 60,
    parameter int IPG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic       tx_en,
    output logic [1:0] txd
);

    localparam int MAXC = (MIN_PAYLOAD > PREAMBLE_BYTES) ? MIN_PAYLOAD : PREAMBLE_BYTES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(IPG_BYTES * 4);

    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_BYTES - 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PAYLOAD);
    localparam logic [IW-1:0] IPG_LAST = IW'(IPG_BYTES * 4 - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
`ifdef PACKET_TX_PAD_EN
        PAD,
`endif
        FCS,
        IPG,
        DROP
    } state_t;

    state_t        state;
    logic [1:0]    dib;
    logic [1:0]    dib_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    fidx;
    logic [1:0]    fidx_nx;
    logic [IW-1:0] ipg_cnt;
    logic [7:0]    shreg;
    logic          last;
    logic [31:0]   crc;
    logic [31:0]   crc_data;
    logic [31:0]   fcs_word;
    logic [7:0]    fcs_first;
    logic [7:0]    fcs_next;
    logic          start;

    // One byte of reflected CRC-32 (poly 0xEDB88320), LSB of data first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign dib_nx    = dib + 2'd1;
    assign fidx_nx   = fidx + 2'd1;
    assign crc_data  = crc_byte(crc, s_axis_tdata);
    assign fcs_word  = ~crc;
    assign fcs_first = fcs_word[7:0];
    assign fcs_next  = fcs_word[{fidx_nx, 3'b000} +: 8];

`ifdef PACKET_TX_PAD_EN
    logic [31:0] crc_pad;
    assign crc_pad = crc_byte(crc, 8'h00);
`endif

    // A frame may begin from IDLE, or straight out of the last gap clock.
    assign start = s_axis_tvalid &&
                   ((state == IDLE) || ((state == IPG) && (ipg_cnt == IPG_LAST)));

    // Byte request: on the last dibit of SFD or a non-final data byte; always while dropping.
    assign s_axis_tready = !rst &&
                           ((state == DROP) ||
                            ((dib == 2'd3) && ((state == SFD) ||
                                               ((state == DATA) && !last))));

    // Frame sequencer; tx_en/txd are registered and show the dibit of the current byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_en   <= 1'b0;
            txd     <= 2'b00;
            dib     <= 2'd0;
            cnt     <= '0;
            fidx    <= 2'd0;
            ipg_cnt <= '0;
            shreg   <= 8'h00;
            last    <= 1'b0;
            crc     <= 32'hFFFFFFFF;
        end else if (start) begin
            state   <= PREAMBLE;
            tx_en   <= 1'b1;
            txd     <= 2'b01;
            dib     <= 2'd0;
            cnt     <= '0;
            fidx    <= 2'd0;
            ipg_cnt <= '0;
            shreg   <= 8'h55;
            last    <= 1'b0;
            crc     <= 32'hFFFFFFFF;
        end else if (tx_en && (dib != 2'd3)) begin
            dib <= dib_nx;
            txd <= shreg[{dib_nx, 1'b0} +: 2];
        end else begin
            case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    txd   <= 2'b00;
                end
                PREAMBLE: begin
                    dib <= 2'd0;
                    txd <= 2'b01;
                    if (cnt == PRE_LAST) begin
                        state <= SFD;
                        shreg <= 8'hD5;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // An empty source at the first payload slot is treated as an underrun too.
                SFD, DATA: begin
                    if ((state == DATA) && last) begin
`ifdef PACKET_TX_PAD_EN
                        if (cnt != MIN_C) begin
                            state <= PAD;
                            shreg <= 8'h00;
                            txd   <= 2'b00;
                            dib   <= 2'd0;
                            crc   <= crc_pad;
                            cnt   <= cnt + CW'(1);
                        end else begin
                            state <= FCS;
                            shreg <= fcs_first;
                            txd   <= fcs_first[1:0];
                            dib   <= 2'd0;
                            fidx  <= 2'd0;
                        end
`else
                        state <= FCS;
                        shreg <= fcs_first;
                        txd   <= fcs_first[1:0];
                        dib   <= 2'd0;
                        fidx  <= 2'd0;
`endif
                    end else if (s_axis_tvalid) begin
                        state <= DATA;
                        shreg <= s_axis_tdata;
                        txd   <= s_axis_tdata[1:0];
                        dib   <= 2'd0;
                        crc   <= crc_data;
                        last  <= s_axis_tlast;
                        if (cnt != MIN_C) cnt <= cnt + CW'(1);
                    end else begin
                        state <= DROP;
                        tx_en <= 1'b0;
                        txd   <= 2'b00;
                        dib   <= 2'd0;
                    end
                end
`ifdef PACKET_TX_PAD_EN
                PAD: begin
                    dib <= 2'd0;
                    if (cnt != MIN_C) begin
                        shreg <= 8'h00;
                        txd   <= 2'b00;
                        crc   <= crc_pad;
                        cnt   <= cnt + CW'(1);
                    end else begin
                        state <= FCS;
                        shreg <= fcs_first;
                        txd   <= fcs_first[1:0];
                        fidx  <= 2'd0;
                    end
                end
`endif
                FCS: begin
                    dib <= 2'd0;
                    if (fidx == 2'd3) begin
                        state   <= IPG;
                        tx_en   <= 1'b0;
                        txd     <= 2'b00;
                        ipg_cnt <= '0;
                    end else begin
                        fidx  <= fidx_nx;
                        shreg <= fcs_next;
                        txd   <= fcs_next[1:0];
                    end
                end
                IPG: begin
                    tx_en   <= 1'b0;
                    txd     <= 2'b00;
                    ipg_cnt <= ipg_cnt + IW'(1);
                    if (ipg_cnt == IPG_LAST) state <= IDLE;
                end
                DROP: begin
                    tx_en <= 1'b0;
                    txd   <= 2'b00;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state   <= IPG;
                        ipg_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_en <= 1'b0;
                    txd   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx_rmii.sv
// tb_packet_tx_rmii: directed and randomized frames against a byte-level frame model.
// Honours PACKET_TX_PAD_EN the same way the design does.
module tb_packet_tx_rmii;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic       tx_en;
    logic [1:0] txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    packet_tx_rmii dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .tx_en(tx_en),
        .txd(txd)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line monitor: decodes dibits into bytes per tx_en burst
    logic [7:0] all_b[$];
    int f_start[64], f_nb[64], f_clk[64], f_gap[64], f_rise[64], f_hs[64], f_bad[64];
    int nf = 0;
    int gap = 0;
    int nd = 0;
    int last_hs = -1;
    logic [7:0] acc_b = 8'h00;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            if (!prev_en) begin
                f_start[nf] = all_b.size();
                f_rise[nf] = cyc;
                f_gap[nf] = gap;
                f_clk[nf] = 0;
                f_hs[nf] = 0;
                f_bad[nf] = 0;
                nd = 0;
                last_hs = -1;
            end
            f_clk[nf]++;
            acc_b[2*nd +: 2] = txd;
            nd++;
            if (nd == 4) begin
                all_b.push_back(acc_b);
                nd = 0;
            end
            if (s_axis_tready === 1'b1 && s_axis_tvalid === 1'b1) begin
                if (last_hs >= 0 && cyc - last_hs != 4) f_bad[nf]++;
                last_hs = cyc;
                f_hs[nf]++;
            end
        end else begin
            if (prev_en) begin
                f_nb[nf] = all_b.size() - f_start[nf];
                if (nf < 63) nf++;
                gap = 0;
            end
            gap++;
        end
        prev_en = (tx_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c0, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c0;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Whole frame as bytes on the wire: preamble, SFD, payload, pad, FCS
    function automatic bq_t model(input bq_t p);
        bq_t q;
        logic [31:0] c;
        logic [31:0] f;
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        foreach (p[i]) q.push_back(p[i]);
`ifdef PACKET_TX_PAD_EN
        while (q.size() - 8 < 60) q.push_back(8'h00);
`endif
        c = 32'hFFFFFFFF;
        for (int i = 8; i < q.size(); i++) c = crc_upd(c, q[i]);
        f = ~c;
        for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
        return q;
    endfunction

    function automatic bq_t rand_pl(input int n);
        bq_t q;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic send(input bq_t q, input bit with_last, output int la);
        la = cyc;
        for (int i = 0; i < q.size(); i++) begin
            int n;
            n = 0;
            s_axis_tdata = q[i];
            s_axis_tlast = with_last && (i == q.size() - 1);
            s_axis_tvalid = 1'b1;
            while (s_axis_tready !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("send_tready", {63'd0, s_axis_tready}, 64'd1);
            @(posedge clk);
            #1;
            la = cyc;
        end
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (nf < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("wait_frame", {63'd0, nf >= target}, 64'd1);
    endtask

    task automatic check_frame(input int idx, input bq_t p, input string tag);
        bq_t e;
        int bad;
        logic [31:0] c;
        e = model(p);
        bad = 0;
        chk({tag, "_clk"}, f_clk[idx], 4 * e.size());
        chk({tag, "_nbytes"}, f_nb[idx], e.size());
        for (int j = 0; j < e.size(); j++) begin
            if (f_start[idx] + j >= all_b.size()) bad++;
            else if (all_b[f_start[idx] + j] !== e[j]) bad++;
        end
        chk({tag, "_bytes"}, bad, 0);
        c = 32'hFFFFFFFF;
        for (int j = 8; j < f_nb[idx]; j++) c = crc_upd(c, all_b[f_start[idx] + j]);
        chk({tag, "_residue"}, c, 32'hDEBB20E3);
    endtask

    initial begin
        bq_t p, p2, hd, tl, e;
        int la, la2, base, c0, n, bad;
        int lens[4];

        // Reset holds the line idle
        repeat (4) begin
            @(negedge clk);
            chk("rst_tx_en", tx_en, 0);
            chk("rst_txd", txd, 0);
            chk("rst_tready", s_axis_tready, 0);
        end
        rst = 1'b0;

        // 64-byte frame
        p = {};
        repeat (63) p.push_back(8'hAA);
        p.push_back(8'hFF);
        base = nf;
        send(p, 1'b1, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 1);
        chk("f64_txen_clk", f_clk[base], 304);
        chk("f64_handshakes", f_hs[base], 64);
        chk("f64_spacing", f_bad[base], 0);
        check_frame(base, p, "f64");

        // 10-byte frame
        p = rand_pl(10);
        base = nf;
        send(p, 1'b1, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 1);
`ifdef PACKET_TX_PAD_EN
        chk("f10_txen_clk", f_clk[base], 288);
`else
        chk("f10_txen_clk", f_clk[base], 88);
`endif
        check_frame(base, p, "f10");

        // 1-byte payload
        p = rand_pl(1);
        base = nf;
        send(p, 1'b1, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 1);
        check_frame(base, p, "f1");

        // Back-to-back frames
        p = rand_pl($urandom_range(1, 70));
        p2 = rand_pl($urandom_range(1, 70));
        base = nf;
        send(p, 1'b1, la);
        send(p2, 1'b1, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 2);
        check_frame(base, p, "b2b_a");
        check_frame(base + 1, p2, "b2b_b");
        chk("b2b_gap", f_gap[base + 1], 48);

        // Underrun after 6 payload bytes
        p = rand_pl(20);
        hd = {};
        tl = {};
        for (int i = 0; i < 6; i++) hd.push_back(p[i]);
        for (int i = 6; i < 20; i++) tl.push_back(p[i]);
        base = nf;
        send(hd, 1'b0, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 1);
        chk("ur_txen_clk", f_clk[base], 56);
        e = model(p);
        bad = 0;
        for (int j = 0; j < 14; j++)
            if (all_b[f_start[base] + j] !== e[j]) bad++;
        chk("ur_bytes", bad, 0);
        repeat (3) @(negedge clk);
        c0 = cyc;
        send(tl, 1'b1, la);
        chk("ur_drop_rate", la - c0, 14);
        p2 = rand_pl($urandom_range(1, 80));
        send(p2, 1'b1, la2);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 2);
        chk("ur_ipg", f_rise[base + 1] - la, 48);
        check_frame(base + 1, p2, "ur_next");

        // Reset pulsed mid-payload
        s_axis_tdata = 8'h3C;
        s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (tx_en !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mr_started", {63'd0, tx_en}, 64'd1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_tx_en", tx_en, 0);
        chk("mr_txd", txd, 0);
        chk("mr_tready", s_axis_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        base = nf;
        p = rand_pl($urandom_range(1, 80));
        send(p, 1'b1, la);
        s_axis_tvalid = 1'b0;
        wait_frames(base + 1);
        check_frame(base, p, "mr_next");

        // Length boundaries around the pad target plus random lengths
        lens[0] = 59;
        lens[1] = 60;
        lens[2] = 61;
        lens[3] = $urandom_range(2, 100);
        for (int k = 0; k < 4; k++) begin
            p = rand_pl(lens[k]);
            base = nf;
            send(p, 1'b1, la);
            s_axis_tvalid = 1'b0;
            wait_frames(base + 1);
            check_frame(base, p, $sformatf("len%0d", lens[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
